acc_drain_serializer: RTL

//  Read-side counterpart to the 34-bit accumulator register bank.
//  - Accepts one WIDTH-bit accumulator word per valid/ready handshake.
//  - Drains it LSB-slice first as NBEATS narrower beats on a valid/ready output bus.
//  - Sits between the PE-array result registers and the narrow result-return path.
//  - Counts completed words for host readback.

---
 rtl/acc_drain_serializer_if.sv | 24 ++
 rtl/acc_drain_serializer.sv | 93 +++++++++
 2 files changed

// File: rtl/acc_drain_serializer_if.sv
// Word-in / beat-out handshake bundle for the accumulator drain serializer.
// The master drives words in and accepts beats; the slave is the serializer.
interface acc_drain_serializer_if #(
    parameter int WIDTH = 34,
    parameter int OUT_W = 17
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/acc_drain_serializer.sv
// Accumulator drain serializer: takes one WIDTH-bit word per handshake and
// emits it LSB slice first as NBEATS beats of OUT_W bits, counting words.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no word held; in_ready=1, out_valid=0
// SEND  | word in hold; beat 'beat' presented; new word taken on last beat
module acc_drain_serializer #(
    parameter int WIDTH  = 34,
    parameter int NBEATS = 2,
    parameter int OUT_W  = 17,
    parameter int CNT_W  = 16
) (
    input  logic                      C,
    input  logic                      R,
    acc_drain_serializer_if.slave     bus,
    output logic                      busy,
    output logic [CNT_W-1:0]          word_count
);
    localparam int            BW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [BW-1:0]      beat, beat_nxt;
    logic [WIDTH-1:0]   hold, hold_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               on_last;

    assign on_last = (beat == LAST);

    // State, beat index, held word and completion counter registers.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state      <= IDLE;
            beat       <= '0;
            hold       <= '0;
            word_count <= '0;
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            hold       <= hold_nxt;
            word_count <= cnt_nxt;
        end
    end

    // Next-state and handshake decode; beat outputs come from registers only.
    always_comb begin
        state_nxt     = state;
        beat_nxt      = beat;
        hold_nxt      = hold;
        cnt_nxt       = word_count;
        bus.in_ready  = 1'b1;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = hold[beat*OUT_W +: OUT_W];
        busy          = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    hold_nxt  = bus.in_data;
                    beat_nxt  = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                bus.out_valid = 1'b1;
                bus.out_last  = on_last;
                busy          = 1'b1;
                // Only the final beat can free the holding register this cycle.
                bus.in_ready  = on_last && bus.out_ready;
                if (bus.out_ready) begin
                    if (!on_last) begin
                        beat_nxt = beat + 1'b1;
                    end else begin
                        cnt_nxt = word_count + 1'b1;
                        if (bus.in_valid) begin
                            hold_nxt = bus.in_data;
                            beat_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
